// File: rtl/inst_fetch_queue.sv
// Fetch stage: credit-limited in-order imem requests, PC-tagged FIFO to decode.
// Define IF_PERF_CNT_EN to add fetch/flush performance counters.
module inst_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int OUT_W = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic        flush,
  output logic        go_next,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [0:0] S_RUN   = 1'b0;
  localparam logic [0:0] S_DRAIN = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [31:0]      inst_mem_q [DEPTH];
  logic [31:0]      pc_mem_q   [DEPTH];
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic [OUT_W-1:0] drop_q, drop_d;
  logic [31:0]      resp_pc_q, resp_pc_d;
  logic             base_q, base_d;
  logic [31:0]      hinst_q, hinst_d;
  logic [31:0]      hpc_q, hpc_d;

  logic credit_ok, grant, push, pop;
  logic rsp_ok, run;

  assign run       = (state_q == S_RUN);
  assign credit_ok = (32'(count_q) + 32'(out_q))
                     < 32'(DEPTH);
  assign imem_req  = run && !flush && credit_ok && !rst;
  assign grant     = imem_req && imem_gnt;
  assign go_next   = grant;
  assign imem_addr = pc_in;

  assign rsp_ok = imem_rvalid
                  && (out_q != '0 || drop_q != '0);
  assign push   = imem_rvalid && run && !flush
                  && (out_q != '0);
  assign pop    = id_valid && id_ready && !flush;

  assign id_valid = (count_q != '0);
  assign id_inst  = hinst_q;
  assign id_pc    = hpc_q;

  always_comb begin
    rptr_d    = pop  ? rptr_q + AW'(1) : rptr_q;
    wptr_d    = push ? wptr_q + AW'(1) : wptr_q;
    count_d   = count_q + CW'(push) - CW'(pop);
    out_d     = out_q + OUT_W'(grant) - OUT_W'(push);
    drop_d    = drop_q;
    resp_pc_d = push ? resp_pc_q + 32'd4 : resp_pc_q;
    base_d    = base_q;
    hinst_d   = hinst_q;
    hpc_d     = hpc_q;

    if (grant && base_q) begin
      resp_pc_d = pc_in;
      base_d    = 1'b0;
    end

    if (!run && imem_rvalid && drop_q != '0)
      drop_d = drop_q - OUT_W'(1);

    // Head registers hold their value once the FIFO empties.
    if (count_d != '0) begin
      if (push && count_q == CW'(pop)) begin
        hinst_d = imem_rdata;
        hpc_d   = resp_pc_q;
      end else begin
        hinst_d = inst_mem_q[rptr_d];
        hpc_d   = pc_mem_q[rptr_d];
      end
    end

    if (flush) begin
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
      drop_d  = out_q + drop_q - OUT_W'(rsp_ok);
      out_d   = '0;
      base_d  = 1'b1;
      hinst_d = hinst_q;
      hpc_d   = hpc_q;
    end

    state_d = (drop_d != '0) ? S_DRAIN : S_RUN;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem_q[wptr_q] <= imem_rdata;
      pc_mem_q[wptr_q]   <= resp_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_RUN;
      rptr_q    <= '0;
      wptr_q    <= '0;
      count_q   <= '0;
      out_q     <= '0;
      drop_q    <= '0;
      resp_pc_q <= '0;
      base_q    <= 1'b1;
      hinst_q   <= '0;
      hpc_q     <= '0;
    end else begin
      state_q   <= state_d;
      rptr_q    <= rptr_d;
      wptr_q    <= wptr_d;
      count_q   <= count_d;
      out_q     <= out_d;
      drop_q    <= drop_d;
      resp_pc_q <= resp_pc_d;
      base_q    <= base_d;
      hinst_q   <= hinst_d;
      hpc_q     <= hpc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && count_q == CW'(DEPTH)))
        else $error("push into full fetch FIFO");
      assert (!imem_rvalid || out_q != '0
              || drop_q != '0)
        else $error("imem_rvalid with nothing in flight");
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] pfetch_q, pflush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pfetch_q <= '0;
      pflush_q <= '0;
    end else begin
      pfetch_q <= pfetch_q + 32'(grant);
      pflush_q <= pflush_q + 32'(flush);
    end
  end

  assign perf_fetch_cnt = pfetch_q;
  assign perf_flush_cnt = pflush_q;
`endif

endmodule
